// File: rtl/project_pkg.sv
// Shared ALU types: data word, primary opcode and extended (shift/rotate) opcode.
package project_pkg;

    typedef logic [7:0] word;

    typedef enum logic [2:0] {
        ALU_CPY = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5,
        ALU_GT  = 3'd6,
        ALU_EXT = 3'd7
    } e_alu_op;

    typedef enum logic [1:0] {
        ALU_SHFL = 2'd0,
        ALU_SHFR = 2'd1,
        ALU_ROTL = 2'd2,
        ALU_ROTR = 2'd3
    } e_alu_ext_op;

endpackage

// File: rtl/alu_seq.sv
// Command sequencer around an external combinational ALU: runs one command
// (single op, or an extended op repeated cnt times) and holds the response.
module alu_seq
    import project_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  e_alu_op          cmd_op,
    input  e_alu_ext_op      cmd_exop,
    input  word              cmd_a,
    input  word              cmd_b,
    input  logic [CNT_W-1:0] cmd_cnt,
    output e_alu_op          alu_op,
    output e_alu_ext_op      alu_exop,
    output word              alu_srcA,
    output word              alu_srcB,
    input  word              alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output word              rsp_result,
    output logic             rsp_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    e_alu_op          op_q, op_d;
    e_alu_ext_op      exop_q, exop_d;
    word              acc_q, acc_d;
    word              b_q, b_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             zero_q, zero_d;
    word              rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_valid_q, rsp_valid_d;

    // Next-state and datapath register updates
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        exop_d       = exop_q;
        acc_d        = acc_q;
        b_d          = b_q;
        rem_d        = rem_q;
        zero_d       = zero_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_valid_d  = rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    exop_d = cmd_exop;
                    acc_d  = cmd_a;
                    b_d    = cmd_b;
                    rem_d  = cmd_cnt;
                    if (cmd_op == ALU_EXT && cmd_cnt == '0) begin
                        // Zero repeat count: operand A passes straight through
                        zero_d       = (cmd_a == '0);
                        rsp_result_d = cmd_a;
                        rsp_zero_d   = (cmd_a == '0);
                        rsp_valid_d  = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                acc_d  = alu_result;
                zero_d = alu_zero;
                if (op_q == ALU_EXT) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                if (op_q != ALU_EXT || rem_q == CNT_W'(1)) begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= ALU_CPY;
            exop_q       <= ALU_SHFL;
            acc_q        <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            zero_q       <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            exop_q       <= exop_d;
            acc_q        <= acc_d;
            b_q          <= b_d;
            rem_q        <= rem_d;
            zero_q       <= zero_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // ALU drive: idle as a copy of zero except while executing
    always_comb begin
        alu_op   = ALU_CPY;
        alu_exop = exop_q;
        alu_srcA = '0;
        alu_srcB = '0;
        if (state_q == S_EXEC) begin
            alu_op   = op_q;
            alu_srcA = acc_q;
            alu_srcB = b_q;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && !rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: local combinational ALU, whole-command reference model,
// per-cycle compare process plus directed literal checks.
module tb_alu_seq;
    import project_pkg::*;

    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    e_alu_op          cmd_op;
    e_alu_ext_op      cmd_exop;
    word              cmd_a, cmd_b;
    logic [CNT_W-1:0] cmd_cnt;
    e_alu_op          alu_op;
    e_alu_ext_op      alu_exop;
    word              alu_srcA, alu_srcB, alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready, rsp_zero;
    word              rsp_result;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_exop(cmd_exop),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
        .alu_op(alu_op), .alu_exop(alu_exop),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    // Combinational ALU; extended ops move one bit per evaluation
    always_comb begin
        case (alu_op)
            ALU_CPY: alu_result = alu_srcA;
            ALU_ADD: alu_result = alu_srcA + alu_srcB;
            ALU_SUB: alu_result = alu_srcA - alu_srcB;
            ALU_AND: alu_result = alu_srcA & alu_srcB;
            ALU_OR:  alu_result = alu_srcA | alu_srcB;
            ALU_XOR: alu_result = alu_srcA ^ alu_srcB;
            ALU_GT:  alu_result = (alu_srcA > alu_srcB) ? 8'd1 : 8'd0;
            default: begin
                case (alu_exop)
                    ALU_SHFL: alu_result = {alu_srcA[6:0], 1'b0};
                    ALU_SHFR: alu_result = {1'b0, alu_srcA[7:1]};
                    ALU_ROTL: alu_result = {alu_srcA[6:0], alu_srcA[7]};
                    default:  alu_result = {alu_srcA[0], alu_srcA[7:1]};
                endcase
            end
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-command result from the operation's definition
    function automatic word ref_result(e_alu_op op, e_alu_ext_op ex, word a, word b, int n);
        logic [15:0] aa;
        aa = {a, a};
        case (op)
            ALU_CPY: return a;
            ALU_ADD: return word'(a + b);
            ALU_SUB: return word'(a - b);
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_GT:  return (a > b) ? 8'd1 : 8'd0;
            default: begin
                case (ex)
                    ALU_SHFL: return word'(a << n);
                    ALU_SHFR: return a >> n;
                    ALU_ROTL: return word'(aa >> (8 - n));
                    default:  return word'(aa >> n);
                endcase
            end
        endcase
    endfunction

    function automatic int ref_latency(e_alu_op op, int n);
        if (op != ALU_EXT) return 2;
        return (n == 0) ? 1 : n + 1;
    endfunction

    // Reference model: idle / busy countdown / holding a response
    bit      m_idle, m_valid, m_zero, m_pzero;
    int      m_cd;
    word     m_res, m_pend, m_b;
    e_alu_op m_op;

    always @(posedge clk) begin
        if (rst) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_cd    = 0;
            m_res   = '0;
            m_zero  = 1'b0;
        end else if (m_idle) begin
            if (cmd_valid) begin
                m_op    = cmd_op;
                m_b     = cmd_b;
                m_pend  = ref_result(cmd_op, cmd_exop, cmd_a, cmd_b, int'(cmd_cnt));
                m_pzero = (m_pend == 8'd0);
                m_cd    = ref_latency(cmd_op, int'(cmd_cnt)) - 1;
                m_idle  = 1'b0;
                if (m_cd == 0) begin
                    m_valid = 1'b1;
                    m_res   = m_pend;
                    m_zero  = m_pzero;
                end
            end
        end else if (m_valid) begin
            if (rsp_ready) begin
                m_valid = 1'b0;
                m_idle  = 1'b1;
            end
        end else begin
            m_cd--;
            if (m_cd == 0) begin
                m_valid = 1'b1;
                m_res   = m_pend;
                m_zero  = m_pzero;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(m_idle && !rst));
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            check("rsp_result", 32'(rsp_result), 32'(m_res));
            check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
            if (!m_idle && !m_valid) begin
                check("alu_op_exec", 32'(alu_op), 32'(m_op));
                check("alu_srcB_exec", 32'(alu_srcB), 32'(m_b));
            end else begin
                check("alu_op_idle", 32'(alu_op), 32'(ALU_CPY));
                check("alu_srcA_idle", 32'(alu_srcA), 32'd0);
                check("alu_srcB_idle", 32'(alu_srcB), 32'd0);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_noise();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = e_alu_op'(3'($urandom_range(0, 7)));
        cmd_exop  = e_alu_ext_op'(2'($urandom_range(0, 3)));
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_cnt   = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat, input bit noise);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            if (noise) drive_noise();
            nxt();
            lat++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_cmd(input e_alu_op op, input e_alu_ext_op ex, input word a, input word b,
                           input logic [2:0] cnt, input int hold, input bit noise,
                           input bit lit, input word exp_res, input bit exp_zero, input int exp_lat);
        int lat;
        nxt();
        cmd_valid = 1'b1;
        cmd_op = op; cmd_exop = ex; cmd_a = a; cmd_b = b; cmd_cnt = cnt;
        nxt();
        cmd_valid = 1'b0;
        wait_valid(lat, noise);
        if (lit) begin
            check("lit_latency", 32'(lat), 32'(exp_lat));
            check("lit_result", 32'(rsp_result), 32'(exp_res));
            check("lit_zero", 32'(rsp_zero), 32'(exp_zero));
        end else begin
            check("latency", 32'(lat), 32'(ref_latency(op, int'(cnt))));
        end
        repeat (hold) begin
            if (noise) drive_noise();
            nxt();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        nxt();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = ALU_CPY; cmd_exop = ALU_SHFL; cmd_a = '0; cmd_b = '0; cmd_cnt = '0;
        repeat (3) nxt();
        rst = 1'b0;
        #1;
        chk_en = 1'b1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);

        // Directed commands with hand-computed results and latencies
        run_cmd(ALU_ADD, ALU_SHFL, 8'd120, 8'd100, 3'd5, 0, 1'b0, 1'b1, 8'd220, 1'b0, 2);
        run_cmd(ALU_SUB, ALU_SHFL, 8'd5, 8'd5, 3'd0, 1, 1'b0, 1'b1, 8'd0, 1'b1, 2);
        run_cmd(ALU_GT, ALU_SHFL, 8'd120, 8'd140, 3'd0, 0, 1'b0, 1'b1, 8'd0, 1'b1, 2);
        run_cmd(ALU_EXT, ALU_SHFL, 8'h78, 8'd0, 3'd3, 0, 1'b0, 1'b1, 8'hC0, 1'b0, 4);
        run_cmd(ALU_EXT, ALU_ROTR, 8'h78, 8'd0, 3'd4, 2, 1'b0, 1'b1, 8'h87, 1'b0, 5);
        run_cmd(ALU_EXT, ALU_SHFR, 8'h78, 8'd0, 3'd0, 0, 1'b0, 1'b1, 8'h78, 1'b0, 1);
        run_cmd(ALU_EXT, ALU_ROTL, 8'h81, 8'd0, 3'd7, 0, 1'b0, 1'b1, 8'hC0, 1'b0, 8);

        // Randomized commands with ignored traffic while busy
        for (int i = 0; i < 80; i++) begin
            run_cmd(e_alu_op'(3'($urandom_range(0, 7))), e_alu_ext_op'(2'($urandom_range(0, 3))),
                    8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                    1'b1, 1'b0, 8'd0, 1'b0, 0);
        end

        // Response held for 5 cycles while a new command waits
        nxt();
        cmd_valid = 1'b1; cmd_op = ALU_ADD; cmd_a = 8'd3; cmd_b = 8'd4; cmd_cnt = 3'd0;
        nxt();
        cmd_op = ALU_SUB; cmd_a = 8'd10; cmd_b = 8'd1;
        wait_valid(lat, 1'b0);
        repeat (5) begin
            check("hold_result", 32'(rsp_result), 32'd7);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            nxt();
        end
        rsp_ready = 1'b1;
        nxt();
        rsp_ready = 1'b0;
        check("queued_cmd_ready", 32'(cmd_ready), 32'd1);
        nxt();
        cmd_valid = 1'b0;
        wait_valid(lat, 1'b0);
        check("queued_latency", 32'(lat), 32'd2);
        check("queued_result", 32'(rsp_result), 32'd9);
        rsp_ready = 1'b1;
        nxt();
        rsp_ready = 1'b0;

        // Reset during the fourth execute cycle of a 7-step rotate
        nxt();
        cmd_valid = 1'b1; cmd_op = ALU_EXT; cmd_exop = ALU_ROTR; cmd_a = 8'h78; cmd_b = 8'd0; cmd_cnt = 3'd7;
        nxt();
        cmd_valid = 1'b0;
        repeat (3) nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_result", 32'(rsp_result), 32'd0);
        check("abort_rsp_zero", 32'(rsp_zero), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_alu_op", 32'(alu_op), 32'(ALU_CPY));
        check("abort_alu_srcA", 32'(alu_srcA), 32'd0);
        repeat (10) begin
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
            nxt();
        end

        run_cmd(ALU_XOR, ALU_SHFL, 8'hF0, 8'h0F, 3'd2, 0, 1'b0, 1'b1, 8'hFF, 1'b0, 2);
        repeat (2) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: CNT_W, default 3, width of shift/rotate repeat count (max repeat 2**CNT_W-1).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous to clk, active-high.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  sequencer can accept command.
REQ-006 cmd_op  in  e_alu_op  requested ALU operation (project_pkg type).
REQ-007 cmd_exop  in  e_alu_ext_op  extended operation when cmd_op == ALU_EXT.
REQ-008 cmd_a / cmd_b  in  word  operands A, B.
REQ-009 cmd_cnt  in  CNT_W  repeat count, used only for ALU_EXT.
REQ-010 alu_op / alu_exop  out  e_alu_op / e_alu_ext_op  drive to combinational ALU instance.
REQ-011 alu_srcA / alu_srcB  out  word  ALU operands.
REQ-012 alu_result  in  word, alu_zero  in  1  combinational ALU outputs, same cycle.
REQ-013 rsp_valid  out  1  result available.
REQ-014 rsp_ready  in  1  consumer accepts result.
REQ-015 rsp_result  out  word, rsp_zero  out  1  final result, result == 0 flag.

Function
REQ-016 States SHALL be IDLE, EXEC, DONE; single command in flight, no overlap.
REQ-017 cmd_ready SHALL be 1 only in IDLE with rst low; command accepted when cmd_valid && cmd_ready on a rising edge.
REQ-018 On accept: latch op, exop, A into accumulator, B, cnt into remaining counter.
REQ-019 Accept with op == ALU_EXT and cnt == 0 SHALL go IDLE->DONE directly: rsp_result = A, rsp_zero = (A == 0); rsp_valid one cycle after accept.
REQ-020 All other accepts SHALL go IDLE->EXEC.
REQ-021 In EXEC: alu_op/alu_exop = latched values, alu_srcA = accumulator, alu_srcB = latched B; each EXEC edge SHALL load alu_result into accumulator and alu_zero into zero register.
REQ-022 Non-EXT op: exactly one EXEC cycle, then DONE; rsp_valid two cycles after accept; cmd_cnt ignored.
REQ-023 EXT op, cnt = N >= 1: exactly N EXEC cycles, remaining decremented each; leave EXEC when remaining reaches 1 at edge; rsp_valid N+1 cycles after accept.
REQ-024 Outside EXEC: alu_op = ALU_CPY, alu_exop = latched value, alu_srcA = alu_srcB = 0.
REQ-025 DONE: rsp_valid = 1; rsp_result = accumulator, rsp_zero = zero register; both stable until handshake.
REQ-026 rsp_valid && rsp_ready edge SHALL return to IDLE; rsp_valid drops next cycle; cmd_ready rises same cycle.
REQ-027 cmd_valid outside IDLE SHALL be ignored, no command state altered.
REQ-028 Arithmetic width rules are the ALU's (8-bit, wrap mod 256); sequencer performs no arithmetic beyond counter decrement.
REQ-029 rsp_result/rsp_zero SHALL keep last values in IDLE and EXEC; only rsp_valid qualifies them.

Reset
REQ-030 rst high at an edge SHALL force IDLE, rsp_valid = 0, rsp_result = 0, rsp_zero = 0, accumulator = 0, remaining = 0, regardless of state.
REQ-031 cmd_ready SHALL be 0 while rst is high; 1 on first cycle after rst falls.
REQ-032 Reset in EXEC or DONE SHALL abandon the command with no response issued.

Verification (bench connects alu_* ports to an alu instance)
REQ-033 ADD A=120 B=100 accepted cycle T -> rsp_valid at T+2, rsp_result=220, rsp_zero=0.
REQ-034 SUB A=5 B=5 -> rsp_result=0, rsp_zero=1; GT A=120 B=140 -> 0, rsp_zero=1.
REQ-035 EXT SHFL A=0x78 cnt=3 -> 3 EXEC cycles, rsp_valid at T+4, rsp_result=0xC0; ROTR A=0x78 cnt=4 -> 0x87.
REQ-036 EXT SHFR A=0x78 cnt=0 -> rsp_valid at T+1, rsp_result=0x78, rsp_zero=0; no EXEC cycle, alu_op stays ALU_CPY.
REQ-037 rsp_ready low 5 cycles in DONE with cmd_valid high -> rsp_result stable, cmd_ready=0, no new command latched; rsp_ready high -> IDLE next cycle, queued command accepted.
REQ-038 EXT ROTR cnt=7, rst pulsed after 3rd EXEC cycle -> IDLE next cycle, rsp_valid never asserted, all outputs at reset values.
